// File: rtl/branch_predictor_if.sv
// Bundle between fetch/resolve logic and the bimodal branch predictor.
// Stat counter wires exist only when BP_STATS_EN is defined.
interface branch_predictor_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] pc_if;
  logic            stall;
  logic            flush;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic            pred_if;
  logic            pred_mem;
  logic            mispredict;
`ifdef BP_STATS_EN
  logic [15:0]     stat_lookups;
  logic [15:0]     stat_miss;

  modport master (
    output pc_if, stall, flush, upd_valid, upd_pc, upd_taken,
    input  pred_if, pred_mem, mispredict, stat_lookups, stat_miss
  );
  modport slave (
    input  pc_if, stall, flush, upd_valid, upd_pc, upd_taken,
    output pred_if, pred_mem, mispredict, stat_lookups, stat_miss
  );
`else
  modport master (
    output pc_if, stall, flush, upd_valid, upd_pc, upd_taken,
    input  pred_if, pred_mem, mispredict
  );
  modport slave (
    input  pc_if, stall, flush, upd_valid, upd_pc, upd_taken,
    output pred_if, pred_mem, mispredict
  );
`endif
endinterface

// File: rtl/branch_predictor.sv
// Bimodal predictor: 2^IDX_W two-bit saturating counters, prediction carried IF->ID->EX->MEM.
// Define BP_STATS_EN to add saturating lookup / mispredict counters.
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int PC_W  = 32
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       bht [ENTRIES];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_ctr;
  // [0]=ID, [1]=EX, [2]=MEM
  logic [2:0]       pred_pipe;

  assign rd_idx = bp.pc_if[IDX_W+1:2];
  assign wr_idx = bp.upd_pc[IDX_W+1:2];
  assign wr_ctr = bht[wr_idx];

  // Read is from the registered array, so a same-cycle update is seen next cycle.
  assign bp.pred_if    = bht[rd_idx][1];
  assign bp.pred_mem   = pred_pipe[2];
  assign bp.mispredict = bp.upd_valid & (bp.upd_taken ^ pred_pipe[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
    end else if (bp.upd_valid) begin
      if (bp.upd_taken) begin
        if (wr_ctr != 2'b11) bht[wr_idx] <= wr_ctr + 2'd1;
      end else begin
        if (wr_ctr != 2'b00) bht[wr_idx] <= wr_ctr - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pred_pipe <= '0;
    else if (bp.flush)   pred_pipe <= '0;
    else if (!bp.stall)  pred_pipe <= {pred_pipe[1:0], bp.pred_if};
  end

`ifdef BP_STATS_EN
  logic [15:0] lookups_q;
  logic [15:0] miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookups_q <= '0;
      miss_q    <= '0;
    end else begin
      if (!bp.stall && !bp.flush && lookups_q != 16'hFFFF) lookups_q <= lookups_q + 16'd1;
      if (bp.mispredict && miss_q != 16'hFFFF)              miss_q    <= miss_q + 16'd1;
    end
  end

  assign bp.stat_lookups = lookups_q;
  assign bp.stat_miss    = miss_q;
`endif

  // Only word-index bits of the PCs select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pc_if[PC_W-1:IDX_W+2], bp.pc_if[1:0],
                            bp.upd_pc[PC_W-1:IDX_W+2], bp.upd_pc[1:0]};
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: reference BHT model plus a prediction scoreboard queue.
module tb_branch_predictor;
  localparam int IDX_W = 6;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.PC_W(PC_W)) bp_if ();

  branch_predictor #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int   mbht [1 << IDX_W];
  logic exp_mem;
  logic pend_q [$];   // predictions still in flight ahead of MEM
  int   m_lookups;
  int   m_miss;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'(pc[IDX_W+1:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < (1 << IDX_W); i++) mbht[i] = 1;
    exp_mem = 1'b0;
    pend_q = {1'b0, 1'b0};
    m_lookups = 0;
    m_miss = 0;
  endtask

  task automatic check_stats(input string tag);
`ifdef BP_STATS_EN
    check({tag, "_lookups"}, {16'h0, bp_if.stat_lookups}, m_lookups);
    check({tag, "_miss"},    {16'h0, bp_if.stat_miss},    m_miss);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One clock: drive at negedge, check combinational/registered outputs, then advance the model.
  task automatic cyc(input logic [31:0] pc, input logic st, input logic fl,
                     input logic uv, input logic [31:0] upc, input logic ut);
    logic exp_pif, exp_mis;
    @(negedge clk);
    bp_if.pc_if = pc;  bp_if.stall = st;  bp_if.flush = fl;
    bp_if.upd_valid = uv;  bp_if.upd_pc = upc;  bp_if.upd_taken = ut;
    #1;
    exp_pif = (mbht[idx(pc)] >= 2);
    exp_mis = uv && (ut != exp_mem);
    check("pred_if", {31'h0, bp_if.pred_if}, {31'h0, exp_pif});
    check("pred_mem", {31'h0, bp_if.pred_mem}, {31'h0, exp_mem});
    check("mispredict", {31'h0, bp_if.mispredict}, {31'h0, exp_mis});
    check_stats("stat");
    @(posedge clk);
    if (uv) begin
      if (ut && mbht[idx(upc)] < 3) mbht[idx(upc)]++;
      if (!ut && mbht[idx(upc)] > 0) mbht[idx(upc)]--;
    end
    if (fl) begin
      exp_mem = 1'b0;
      pend_q = {1'b0, 1'b0};
    end else if (!st) begin
      exp_mem = pend_q.pop_front();
      pend_q.push_back(exp_pif);
    end
    if (!st && !fl && m_lookups < 16'hFFFF) m_lookups++;
    if (exp_mis && m_miss < 16'hFFFF) m_miss++;
  endtask

  task automatic idle(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) cyc(pc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  logic [31:0] pc_tab [5];

  initial begin
    pc_tab[0] = 32'h40;  pc_tab[1] = 32'h44;  pc_tab[2] = 32'h80;
    pc_tab[3] = 32'h100; pc_tab[4] = 32'h0;
    bp_if.pc_if = 32'h40; bp_if.stall = 1'b0; bp_if.flush = 1'b0;
    bp_if.upd_valid = 1'b0; bp_if.upd_pc = '0; bp_if.upd_taken = 1'b0;
    model_reset();
    #1;
    check("rst_pred_if", {31'h0, bp_if.pred_if}, 32'h0);
    check("rst_pred_mem", {31'h0, bp_if.pred_mem}, 32'h0);
    check_stats("rst");
    @(negedge clk); rst_n = 1'b1;

    // cold lookup of 0x40 predicts not-taken all the way to MEM
    idle(32'h40, 4);

    // two taken updates saturate toward strong-T, third stays at 11
    cyc(32'h40, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    cyc(32'h40, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    cyc(32'h40, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    check("ctr_sat_hi", mbht[idx(32'h40)], 3);
    idle(32'h40, 3);

    // pred_mem=1 with not-taken outcome -> mispredict, counter still predicts taken
    cyc(32'h40, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    idle(32'h40, 3);

    // stalls hold the pipeline, then flush+stall clears a full 1,1,1 pipe
    cyc(32'h80, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(32'h80, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(32'h40, 1'b1, 1'b1, 1'b1, 32'h44, 1'b1);
    idle(32'h40, 4);

    // same-cycle lookup/update at 0x80: old value now, new value next cycle
    cyc(32'h80, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1);
    cyc(32'h80, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // not-taken updates saturate at 00 (0x100 aliases index 0)
    for (int i = 0; i < 3; i++) cyc(32'h0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    check("ctr_sat_lo", mbht[0], 0);

    // random mix of lookups, stalls, flushes, updates
    for (int i = 0; i < 300; i++)
      cyc(pc_tab[$urandom_range(4)], ($urandom_range(4) == 0), ($urandom_range(9) == 0),
          ($urandom_range(1) == 1), pc_tab[$urandom_range(4)], ($urandom_range(1) == 1));

    // asynchronous reset mid-run clears everything without a clock
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_pred_mem", {31'h0, bp_if.pred_mem}, 32'h0);
    check_stats("arst");
    @(negedge clk); rst_n = 1'b1;
    bp_if.upd_valid = 1'b0;
    idle(32'h40, 4);
    cyc(32'h40, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    idle(32'h40, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end
endmodule
